// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//
// Transmit side of the UART. Bytes written from the bus side are buffered in a
// DEPTH-entry FIFO and serialised onto tx_out as start bit, DATA_W data bits
// (LSB first), optional even-parity bit, and stop bit. Each bit lasts
// BIT_PERIOD clocks. While the FIFO holds data, frames are sent back to back
// with no idle bit between them.
//
// Parameters
//   DEPTH       FIFO entries (power of 2, >= 2)
//   DATA_W      bits per word and per frame
//   BIT_PERIOD  clocks per serial bit (>= 2)
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   w_enable  in   write strobe, w_data is pushed on the edge where it is high
//   w_data    in   byte to transmit
//   tx_out    out  serial line, idle high (registered)
//   empty     out  FIFO holds no words (a frame may still be in flight)
//   full      out  FIFO holds DEPTH words
//   busy      out  frame in progress (FSM not IDLE)
//   tx_done   out  one-cycle pulse on the last clock of each stop bit
//
// Build option
//   UART_TX_PARITY_EN  when defined, a PARITY state after DATA sends the
//                      even-parity bit (XOR of the data bits).
//
// Write handshake: there is no ready signal. w_enable is a one-cycle strobe
// that is accepted when full is low; a strobe while full is dropped without
// any state change, even if the FSM pops a word on the same edge.
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int DEPTH      = 8,
    parameter int DATA_W     = 8,
    parameter int BIT_PERIOD = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              w_enable,
    input  logic [DATA_W-1:0] w_data,
    output logic              tx_out,
    output logic              empty,
    output logic              full,
    output logic              busy,
    output logic              tx_done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = $clog2(BIT_PERIOD);
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CW-1:0] COUNT_FULL  = CW'(DEPTH);
    localparam logic [PW-1:0] PERIOD_LAST = PW'(BIT_PERIOD - 1);
    localparam logic [BW-1:0] BIT_LAST    = BW'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t state;
    state_t state_next;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_next;

    logic [PW-1:0]     period_cnt;
    logic [BW-1:0]     bit_cnt;
    logic [DATA_W-1:0] shift;

`ifdef UART_TX_PARITY_EN
    logic              parity_bit;
`endif

    logic push;
    logic pop;
    logic line;
    logic period_last;
    logic bit_last;
    logic stop_end;

    // full is registered, so a word leaving on this edge does not make room
    // for a write on the same edge.
    assign push        = w_enable && !full && !rst;
    assign period_last = (period_cnt == PERIOD_LAST);
    assign bit_last    = (bit_cnt == BIT_LAST);
    assign stop_end    = (state == STOP) && period_last;
    assign busy        = (state != IDLE);

    // Next state, pop request and the line level for the current state.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        line       = 1'b1;
        case (state)
            IDLE: begin
                line = 1'b1;
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                line = 1'b0;
                if (period_last) state_next = DATA;
            end
            DATA: begin
                line = shift[0];
                if (period_last && bit_last) begin
`ifdef UART_TX_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                line = parity_bit;
                if (period_last) state_next = STOP;
            end
`endif
            STOP: begin
                line = 1'b1;
                // Chain straight into the next frame when a word is waiting.
                if (period_last) begin
                    if (!empty) begin
                        pop        = 1'b1;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                line       = 1'b1;
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Storage is not reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= w_data;
        end
    end

    // tx_out and tx_done are registered from the current state, so the line
    // follows the FSM one clock later (pop edge -> start bit the edge after).
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            empty      <= 1'b1;
            full       <= 1'b0;
            period_cnt <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            tx_out     <= 1'b1;
            tx_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            count   <= count_next;
            empty   <= (count_next == '0);
            full    <= (count_next == COUNT_FULL);
            tx_out  <= line;
            tx_done <= stop_end;

            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);

            if (state == IDLE || period_last) begin
                period_cnt <= '0;
            end else begin
                period_cnt <= period_cnt + PW'(1);
            end

            if (state == DATA && period_last) begin
                bit_cnt <= bit_last ? '0 : bit_cnt + BW'(1);
            end

            if (pop) begin
                shift <= mem[rd_ptr];
            end else if (state == DATA && period_last) begin
                shift <= shift >> 1;
            end

`ifdef UART_TX_PARITY_EN
            if (pop) begin
                parity_bit <= ^mem[rd_ptr];
            end
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
//
// Directed bench for uart_tx_fifo with BIT_PERIOD=4, DEPTH=8. A reference
// model expands every popped byte into the list of line samples it must
// produce and tracks FIFO occupancy as a queue; a per-cycle compare checks
// tx_out, tx_done, busy, empty and full against it. A small line receiver
// decodes tx_out and scores decoded bytes against an expected queue. Directed
// tests add hand-written literal expectations.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

    localparam int DEPTH  = 8;
    localparam int DATA_W = 8;
    localparam int BP     = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = DATA_W + 3;
`else
    localparam int FRAME_BITS = DATA_W + 2;
`endif
    localparam int FRAME_CLKS = FRAME_BITS * BP;

    // ---------------- clock / reset / DUT ----------------
    logic              clk = 1'b0;
    logic              rst;
    logic              w_enable;
    logic [DATA_W-1:0] w_data;
    logic              tx_out;
    logic              empty;
    logic              full;
    logic              busy;
    logic              tx_done;

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .DEPTH      (DEPTH),
        .DATA_W     (DATA_W),
        .BIT_PERIOD (BP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .w_enable (w_enable),
        .w_data   (w_data),
        .tx_out   (tx_out),
        .empty    (empty),
        .full     (full),
        .busy     (busy),
        .tx_done  (tx_done)
    );

    // ---------------- bookkeeping ----------------
    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit model_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DATA_W-1:0] m_fifo[$];
    logic              line_q[$];
    logic              done_q[$];
    logic [DATA_W-1:0] exp_q[$];
    logic exp_tx    = 1'b1;
    logic exp_done  = 1'b0;
    logic exp_busy  = 1'b0;
    logic exp_empty = 1'b1;
    logic exp_full  = 1'b0;

    // Expand one byte into its line samples: start, data LSB first,
    // optional even parity, stop; each bit held BP clocks.
    task automatic push_frame(input logic [DATA_W-1:0] b);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < DATA_W; i++) bits.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
        bits.push_back(^b);
`endif
        bits.push_back(1'b1);
        for (int j = 0; j < bits.size(); j++) begin
            for (int r = 0; r < BP; r++) begin
                line_q.push_back(bits[j]);
                done_q.push_back((j == bits.size() - 1) && (r == BP - 1));
            end
        end
        exp_q.push_back(b);
    endtask

    // ---------------- line receiver / scoreboard state ----------------
    bit                rx_active = 1'b0;
    int                rx_pos    = 0;
    logic [DATA_W-1:0] rx_shift  = '0;
    logic [DATA_W-1:0] rx_log[$];
    int                done_log[$];
    int                low_cnt   = 0;

    always @(posedge clk) begin
        bit accept;
        cyc++;
        // Model update for this edge, using the inputs it samples.
        if (rst === 1'b1) begin
            m_fifo.delete();
            line_q.delete();
            done_q.delete();
            exp_q.delete();
            exp_tx      = 1'b1;
            exp_done    = 1'b0;
            model_valid = 1'b1;
        end else begin
            accept = (w_enable === 1'b1) && (m_fifo.size() < DEPTH);
            if (line_q.size() > 0) begin
                exp_tx   = line_q.pop_front();
                exp_done = done_q.pop_front();
            end else begin
                exp_tx   = 1'b1;
                exp_done = 1'b0;
            end
            // A new frame starts once the previous one has emitted its last sample.
            if (line_q.size() == 0 && m_fifo.size() > 0) begin
                push_frame(m_fifo.pop_front());
            end
            if (accept) m_fifo.push_back(w_data);
        end
        exp_busy  = (line_q.size() > 0);
        exp_empty = (m_fifo.size() == 0);
        exp_full  = (m_fifo.size() == DEPTH);

        #1;
        if (model_valid) begin
            check("cyc_tx_out",  tx_out,  exp_tx);
            check("cyc_tx_done", tx_done, exp_done);
            check("cyc_busy",    busy,    exp_busy);
            check("cyc_empty",   empty,   exp_empty);
            check("cyc_full",    full,    exp_full);
        end

        // Receiver: sample each bit in its middle clock.
        if (rst === 1'b1) begin
            rx_active = 1'b0;
        end else if (!rx_active) begin
            if (tx_out === 1'b0) begin
                rx_active = 1'b1;
                rx_pos    = 0;
            end
        end else begin
            rx_pos++;
            if (rx_pos >= BP && rx_pos < BP * (1 + DATA_W) && (rx_pos % BP) == BP / 2)
                rx_shift[rx_pos / BP - 1] = tx_out;
            if (rx_pos == BP * (FRAME_BITS - 1) + BP / 2) begin
                check("rx_stop_bit", tx_out, 1'b1);
                rx_log.push_back(rx_shift);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL rx_extra: got byte %0h, expected no frame", rx_shift);
                end else begin
                    check("rx_byte", rx_shift, exp_q.pop_front());
                end
            end
            if (rx_pos == FRAME_CLKS - 1) rx_active = 1'b0;
        end

        if (tx_done === 1'b1) done_log.push_back(cyc);
        if (model_valid && tx_out === 1'b0) low_cnt++;
    end

    // ---------------- driver tasks (called at a falling edge) ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [DATA_W-1:0] b);
        w_enable = 1'b1;
        w_data   = b;
        @(negedge clk);
        w_enable = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (!(busy === 1'b0 && empty === 1'b1) && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle_reached", {busy, empty}, 2'b01);
        tick(2);
    endtask

    // Write one byte into an idle block and check the line sample by sample
    // against a literal frame (bit 0 = start bit).
    task automatic send_and_check(input logic [DATA_W-1:0] b, input logic [11:0] bits,
                                  input int nbits, input string tag);
        logic exp_bit;
        wr(b);
        for (int k = 1; k <= nbits * BP + 3; k++) begin
            @(negedge clk);
            if (k >= 2 && k < 2 + nbits * BP) exp_bit = bits[(k - 2) / BP];
            else                              exp_bit = 1'b1;
            check({tag, "_line"}, tx_out, exp_bit);
            check({tag, "_done"}, tx_done, (k == nbits * BP + 1));
        end
        check({tag, "_busy_after"},  busy,  1'b0);
        check({tag, "_empty_after"}, empty, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lows;
        rst      = 1'b1;
        w_enable = 1'b0;
        w_data   = '0;

        // Reset held for two clocks.
        tick(2);
        check("rst_tx_out",  tx_out,  1'b1);
        check("rst_empty",   empty,   1'b1);
        check("rst_full",    full,    1'b0);
        check("rst_busy",    busy,    1'b0);
        check("rst_tx_done", tx_done, 1'b0);
        rst = 1'b0;
        tick(2);

        // Single byte 0xA5.
`ifdef UART_TX_PARITY_EN
        send_and_check(8'hA5, {1'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, 11, "a5");
`else
        send_and_check(8'hA5, {2'b00, 1'b1, 8'hA5, 1'b0}, 10, "a5");
`endif
        tick(3);

        // Fill: nine words, then a dropped tenth.
        done_log.delete();
        rx_log.delete();
        for (int i = 1; i <= 9; i++) wr(8'(i));
        check("fill_full_after_9", full, 1'b1);
        wr(8'hFF);
        check("fill_full_hold",  full,  1'b1);
        check("fill_not_empty",  empty, 1'b0);
        wait_idle(1000);
        check("fill_frame_count", rx_log.size(), 9);
        for (int i = 0; i < rx_log.size(); i++) check("fill_order", rx_log[i], i + 1);
        check("fill_done_count", done_log.size(), 9);
        for (int i = 1; i < done_log.size(); i++)
            check("fill_no_gap", done_log[i] - done_log[i - 1], FRAME_CLKS);

        // Reset during data bit 3 with three words queued.
        rx_log.delete();
        wr(8'h11);
        wr(8'h22);
        wr(8'h33);
        wr(8'h44);
        tick(15);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_tx_out",  tx_out,  1'b1);
        check("abort_empty",   empty,   1'b1);
        check("abort_busy",    busy,    1'b0);
        check("abort_full",    full,    1'b0);
        check("abort_tx_done", tx_done, 1'b0);
        lows = low_cnt;
        tick(100);
        check("abort_no_frames", rx_log.size(), 0);
        check("abort_line_high", low_cnt - lows, 0);

        // Write landing on the stop-end edge of the previous frame.
        rx_log.delete();
        wr(8'h55);
        tick(FRAME_CLKS);
        wr(8'h3C);
        check("stopedge_done", tx_done, 1'b1);
        check("stopedge_stop", tx_out,  1'b1);
        @(negedge clk);
        check("stopedge_idle_bit", tx_out, 1'b1);
        check("stopedge_busy",     busy,   1'b1);
        @(negedge clk);
        check("stopedge_start", tx_out, 1'b0);
        wait_idle(200);
        check("stopedge_frames", rx_log.size(), 2);
        if (rx_log.size() == 2) check("stopedge_byte", rx_log[1], 8'h3C);
        tick(3);

`ifdef UART_TX_PARITY_EN
        // 0x07: three ones, parity bit 1, 44-clock frame.
        send_and_check(8'h07, {1'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, "par07");
`else
        send_and_check(8'h81, {2'b00, 1'b1, 8'h81, 1'b0}, 10, "b81");
`endif
        tick(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
